// File: rtl/seq_alu_booth.sv
// seq_alu_booth: registered MIPS-style ALU with valid/ready handshake and a
// multi-cycle radix-2 Booth signed multiplier producing a 2*WIDTH product.
module seq_alu_booth #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUCnt,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               Zero
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic               pend_q, pend_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [SHAMT_W-1:0] sh_q, sh_d, cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d, m_q, m_d, acc_sum;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic               qm1_q, qm1_d;
  logic               out_valid_q, out_valid_d, zero_q, zero_d;
  logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d, alu_r;
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign Zero      = zero_q;
  always_comb begin
    alu_r = '0;
    case (op_q)
      4'd0: alu_r = a_q & b_q;
      4'd1: alu_r = a_q | b_q;
      4'd2: alu_r = a_q + b_q;
      4'd3: alu_r = b_q << sh_q;
      4'd4: alu_r = b_q >> sh_q;
      4'd5: alu_r = a_q - b_q;
      4'd6: alu_r = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      4'd7: alu_r = ~(a_q | b_q);
      4'd9: alu_r = $signed(b_q) >>> sh_q;
      default: alu_r = '0;
    endcase
  end
  // Booth recoding of {Q[0],Q_-1}: 01 adds M, 10 subtracts M
  assign acc_sum = ({mq_q[0], qm1_q} == 2'b01) ? acc_q + m_q :
                   ({mq_q[0], qm1_q} == 2'b10) ? acc_q - m_q : acc_q;
  always_comb begin
    state_d     = state_q;
    pend_d      = 1'b0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    m_d         = m_q;
    mq_d        = mq_q;
    qm1_d       = qm1_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    if (in_valid && in_ready) begin
      op_d   = ALUCnt;
      a_d    = input1;
      b_d    = input2;
      sh_d   = Shamt;
      pend_d = ALUCnt != 4'd8;
    end
    if (pend_q) begin
      out_valid_d = 1'b1;
      result_d    = alu_r;
      result_hi_d = '0;
      zero_d      = alu_r == '0;
    end
    case (state_q)
      IDLE: if (in_valid && ALUCnt == 4'd8) begin
        state_d = MUL;
        acc_d   = '0;
        m_d     = {input1[WIDTH-1], input1};
        mq_d    = input2;
        qm1_d   = 1'b0;
        cnt_d   = '0;
      end
      MUL: begin
        acc_d   = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        mq_d    = {acc_sum[0], mq_q[WIDTH-1:1]};
        qm1_d   = mq_q[0];
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == SHAMT_W'(WIDTH-1)) ? DONE : MUL;
      end
      DONE: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        result_d    = mq_q;
        result_hi_d = acc_q[WIDTH-1:0];
        zero_d      = ~|{acc_q[WIDTH-1:0], mq_q};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      m_q         <= '0;
      mq_q        <= '0;
      qm1_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      mq_q        <= mq_d;
      qm1_q       <= qm1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
    end
  end
endmodule

// File: tb/tb_seq_alu_booth.sv
// tb_seq_alu_booth: scoreboard bench driving a 32-bit and a 16-bit instance
// against an arithmetic reference model.
module tb_seq_alu_booth;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    longint      cyc;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic v32 = 0, v16 = 0;
  logic [3:0] alucnt = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic [4:0] sh = 0;
  logic rdy32, rdy16, o32, o16, z32, z16;
  logic [31:0] r32, h32;
  logic [15:0] r16, h16;
  longint cyc = 0;
  int errors = 0, checks = 0;
  exp_t q32[$], q16[$];
  exp_t e32, e16;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  seq_alu_booth #(.WIDTH(32), .SHAMT_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .ALUCnt(alucnt),
    .input1(in1), .input2(in2), .Shamt(sh), .out_valid(o32), .result(r32),
    .result_hi(h32), .Zero(z32));
  seq_alu_booth #(.WIDTH(16), .SHAMT_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .ALUCnt(alucnt),
    .input1(in1[15:0]), .input2(in2[15:0]), .Shamt(sh[3:0]), .out_valid(o16),
    .result(r16), .result_hi(h16), .Zero(z16));
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] s_in);
    exp_t e;
    longint m = (longint'(1) << w) - 1;
    longint ua = a & m, ub = b & m;
    longint sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    longint sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    int s = int'(s_in) & (w - 1);
    longint r = 0, h = 0, p;
    p = sa * sb;
    case (op)
      0: r = ua & ub;
      1: r = ua | ub;
      2: r = ua + ub;
      3: r = ub << s;
      4: r = ub >> s;
      5: r = ua - ub;
      6: r = (sa < sb) ? 1 : 0;
      7: r = ~(ua | ub);
      8: begin r = p; h = p >>> w; end
      9: r = sb >>> s;
      default: r = 0;
    endcase
    r = r & m;
    h = h & m;
    e.lo = r[31:0];
    e.hi = h[31:0];
    e.z = (r == 0) && (h == 0);
    e.cyc = 0;
    return e;
  endfunction
  always @(negedge clk) if (o32) begin
    if (q32.size() == 0) begin
      checks++; errors++;
      $display("FAIL w32 unexpected out_valid at cycle %0d", cyc);
    end else begin
      e32 = q32.pop_front();
      chk("w32 result", r32, e32.lo);
      chk("w32 result_hi", h32, e32.hi);
      chk("w32 Zero", z32, e32.z);
      chk("w32 pulse cycle", cyc, e32.cyc);
    end
  end
  always @(negedge clk) if (o16) begin
    if (q16.size() == 0) begin
      checks++; errors++;
      $display("FAIL w16 unexpected out_valid at cycle %0d", cyc);
    end else begin
      e16 = q16.pop_front();
      chk("w16 result", r16, e16.lo);
      chk("w16 result_hi", h16, e16.hi);
      chk("w16 Zero", z16, e16.z);
      chk("w16 pulse cycle", cyc, e16.cyc);
    end
  end
  task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s, output longint k);
    int n = 0;
    int w = sel ? 16 : 32;
    exp_t e;
    alucnt = op; in1 = a; in2 = b; sh = s;
    if (sel) v16 = 1; else v32 = 1;
    while (!(sel ? rdy16 : rdy32) && n < 200) begin @(negedge clk); n++; end
    k = -1;
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s issue timeout op=%0d", sel ? "w16" : "w32", op);
    end else begin
      @(posedge clk); #1;
      k = cyc;
      e = model(w, op, a, b, s);
      e.cyc = k + ((op == 4'd8) ? w + 1 : 1);
      if (sel) q16.push_back(e); else q32.push_back(e);
      @(negedge clk);
    end
    v32 = 0; v16 = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 300) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("w32 drained", q32.size(), 0);
    chk("w16 drained", q16.size(), 0);
  endtask
  task automatic run(input bit sel);
    int w = sel ? 16 : 32;
    int n;
    longint k, k2;
    logic [31:0] msb = 32'h1 << (w - 1);
    for (int i = 0; i < 8; i++) issue(sel, 4'(i), 4, 5, 2, k);
    issue(sel, 5, 5, 5, 0, k);
    issue(sel, 12, 3, 9, 1, k);
    issue(sel, 9, 0, msb, 4, k);
    issue(sel, 3, 0, 32'h1234_5678, 0, k);
    issue(sel, 8, 4, 5, 0, k);
    n = 0;
    while (!(sel ? rdy16 : rdy32) && n < 200) begin n++; @(negedge clk); end
    chk(sel ? "w16 mul busy cycles" : "w32 mul busy cycles", n, w + 1);
    issue(sel, 8, 32'hFFFF_FFFD, 7, 0, k);
    issue(sel, 8, msb, msb, 0, k);
    issue(sel, 8, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, k);
    issue(sel, 2, 11, 22, 0, k2);
    chk(sel ? "w16 held add accept" : "w32 held add accept", k2, k + w + 2);
    issue(sel, 8, 0, msb - 1, 0, k);
    for (int i = 0; i < 40; i++)
      issue(sel, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), k);
    drain();
  endtask
  initial begin
    longint k;
    repeat (3) @(negedge clk);
    chk("reset out_valid", o32, 0);
    chk("reset result", r32, 0);
    chk("reset result_hi", h32, 0);
    chk("reset Zero", z32, 0);
    chk("reset in_ready", rdy32, 1);
    rst_n = 1;
    @(negedge clk);
    run(0);
    issue(0, 2, 1, 2, 0, k);
    issue(0, 8, 7, 9, 0, k);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid-mul reset out_valid", o32, 0);
    chk("mid-mul reset result", r32, 0);
    chk("mid-mul reset result_hi", h32, 0);
    chk("mid-mul reset Zero", z32, 0);
    chk("mid-mul reset in_ready", rdy32, 1);
    q32.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post-reset in_ready", rdy32, 1);
    issue(0, 2, 1, 1, 0, k);
    drain();
    run(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
